// File: rtl/barcode_pkg.sv
// barcode_pkg: shared states and constants for the barcode receiver
package barcode_pkg;
   typedef enum logic [2:0] {IDLE, MEAS, WAIT_FALL, SAMPLE, DONE} bc_state_t;
   localparam int ID_W = 8;
   localparam logic [1:0] RSV_OK = 2'b00;
endpackage

// File: rtl/bc_sync.sv
// bc_sync: two-flop synchronizer plus history flop with edge detect
module bc_sync (
   input  logic clk,
   input  logic rst,
   input  logic bc,
   output logic bc_s,
   output logic fall,
   output logic rise
);
   logic s1, hist;
   always_ff @(posedge clk)
      if (rst) {s1, bc_s, hist} <= 3'b111;
      else {s1, bc_s, hist} <= {bc, s1, bc_s};
   assign fall = ~bc_s & hist;
   assign rise = bc_s & ~hist;
endmodule

// File: rtl/barcode_rx.sv
// barcode_rx: self-timed serial barcode decoder producing a sticky station ID
module barcode_rx
   import barcode_pkg::*;
#(
   parameter int CNT_W = 22,
   parameter int NBITS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            BC,
   input  logic            clr_ID_vld,
   output logic [ID_W-1:0] ID,
   output logic            ID_vld
);
   localparam int BW = $clog2(NBITS + 1);
   localparam logic [CNT_W-1:0] TMAX = '1;
   bc_state_t state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt, timer_inc, period, period_nxt;
   logic [BW-1:0] bit_cnt, bit_cnt_nxt;
   logic [ID_W-1:0] shift, shift_nxt, id_nxt;
   logic vld_nxt, bc_s, fall, rise, tmo;
   bc_sync u_sync (.clk(clk), .rst(rst), .bc(BC), .bc_s(bc_s), .fall(fall), .rise(rise));
   assign tmo = timer == TMAX;
   assign timer_inc = tmo ? timer : timer + 1'b1;
   always_ff @(posedge clk)
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         period  <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         ID      <= '0;
         ID_vld  <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         period  <= period_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift   <= shift_nxt;
         ID      <= id_nxt;
         ID_vld  <= vld_nxt;
      end
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      period_nxt  = period;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      id_nxt      = ID;
      vld_nxt     = ID_vld & ~clr_ID_vld;
      case (state)
         IDLE:
            if (fall) begin
               state_nxt   = MEAS;
               timer_nxt   = '0;
               bit_cnt_nxt = '0;
            end
         MEAS:
            if (tmo) state_nxt = IDLE;
            else if (rise) begin
               period_nxt = timer;
               state_nxt  = WAIT_FALL;
            end else if (!bc_s) timer_nxt = timer_inc;
         WAIT_FALL:
            if (tmo) state_nxt = IDLE;
            else if (fall) begin
               timer_nxt = '0;
               state_nxt = SAMPLE;
            end else timer_nxt = timer_inc;
         SAMPLE:
            if (tmo) state_nxt = IDLE;
            else begin
               timer_nxt = timer_inc;
               if (timer == period) begin
                  shift_nxt   = {shift[ID_W-2:0], bc_s};
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  state_nxt   = (bit_cnt_nxt == BW'(NBITS)) ? DONE : WAIT_FALL;
               end
            end
         DONE: begin
            state_nxt = IDLE;
            if (shift[ID_W-1 -: 2] == RSV_OK) begin
               id_nxt  = shift;
               vld_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_barcode_rx.sv
// tb_barcode_rx: table-driven frames with a scoreboard, plus timeout, reset and set-vs-clear sequences
module tb_barcode_rx;
   import barcode_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1, rst8 = 1'b1;
   logic bc = 1'b1, bc8 = 1'b1, clr = 1'b0, clr8 = 1'b0;
   logic [7:0] id, id8;
   logic vld, vld8, vld_d = 1'b0;
   int cyc = 0, last_fall = 0, rise_cyc = -1;
   int n_chk = 0, n_fail = 0;
   typedef struct {int t; logic [7:0] d; bit clr; logic [7:0] eid; logic evld;} vec_t;
   typedef struct {bit sel; logic [7:0] id; logic vld;} exp_t;
   vec_t v[8];
   exp_t sb[$];
   barcode_rx dut (.clk(clk), .rst(rst), .BC(bc), .clr_ID_vld(clr), .ID(id), .ID_vld(vld));
   barcode_rx #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst8), .BC(bc8), .clr_ID_vld(clr8), .ID(id8), .ID_vld(vld8));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      vld_d <= vld;
      if (vld && !vld_d) rise_cyc <= cyc;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic pop_chk(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, " id"}, e.sel ? id8 : id, e.id);
         chk({nm, " vld"}, e.sel ? vld8 : vld, e.vld);
      end
   endtask
   task automatic drv(input bit sel, input logic val, input int n);
      if (sel) bc8 = val;
      else bc = val;
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bits(input bit sel, input int t, input logic [7:0] d, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         if (!sel) last_fall = cyc;
         drv(sel, 1'b0, d[i] ? t / 2 : 3 * t / 2);
         drv(sel, 1'b1, d[i] ? 3 * t / 2 : t / 2);
      end
   endtask
   task automatic send_frame(input bit sel, input int t, input logic [7:0] d);
      drv(sel, 1'b0, t);
      drv(sel, 1'b1, t);
      send_bits(sel, t, d, 7, 0);
   endtask
   initial begin
      int k;
      v[0] = '{1000, 8'h2A, 1'b0, 8'h2A, 1'b1};
      v[1] = '{100,  8'hC5, 1'b0, 8'h2A, 1'b1};
      v[2] = '{100,  8'hC5, 1'b1, 8'h2A, 1'b0};
      v[3] = '{200,  8'h3F, 1'b0, 8'h3F, 1'b1};
      v[4] = '{2000, 8'h3F, 1'b1, 8'h3F, 1'b1};
      v[5] = '{60,   8'h81, 1'b0, 8'h3F, 1'b1};
      v[6] = '{40,   8'h00, 1'b0, 8'h00, 1'b1};
      v[7] = '{30,   8'h15, 1'b0, 8'h15, 1'b1};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rst8 = 1'b0;
      chk("reset id", id, 8'h00);
      chk("reset vld", vld, 1'b0);
      chk("reset id8", id8, 8'h00);
      chk("reset vld8", vld8, 1'b0);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (v[i].clr) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            chk($sformatf("clr row%0d", i), vld, 1'b0);
         end
         sb.push_back('{1'b0, v[i].eid, v[i].evld});
         send_frame(1'b0, v[i].t, v[i].d);
         repeat (10) @(negedge clk);
         pop_chk($sformatf("row%0d", i));
         if (i == 0) chk("latency 2A", (rise_cyc - last_fall >= 1000) && (rise_cyc - last_fall <= 1006), 1'b1);
      end
      sb.push_back('{1'b0, 8'h11, 1'b1});
      fork
         send_frame(1'b0, 50, 8'h11);
         begin
            k = 0;
            while (dut.state != DONE && k < 5000) begin
               @(negedge clk);
               k++;
            end
            if (k >= 5000) chk("done reached", 0, 1);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
         end
      join
      repeat (10) @(negedge clk);
      pop_chk("set_wins 11");
      drv(1'b1, 1'b0, 300);
      drv(1'b1, 1'b1, 5);
      chk("timeout vld8", vld8, 1'b0);
      chk("timeout id8", id8, 8'h00);
      sb.push_back('{1'b1, 8'h05, 1'b1});
      send_frame(1'b1, 40, 8'h05);
      repeat (10) @(negedge clk);
      pop_chk("after_timeout 05");
      drv(1'b1, 1'b0, 40);
      drv(1'b1, 1'b1, 40);
      send_bits(1'b1, 40, 8'h2C, 7, 4);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      chk("midrst id8", id8, 8'h00);
      chk("midrst vld8", vld8, 1'b0);
      send_bits(1'b1, 40, 8'h2C, 3, 0);
      repeat (300) @(negedge clk);
      chk("leftover vld8", vld8, 1'b0);
      sb.push_back('{1'b1, 8'h3A, 1'b1});
      send_frame(1'b1, 40, 8'h3A);
      repeat (10) @(negedge clk);
      pop_chk("post_rst 3A");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
